// File: rtl/vec_accum.sv
`default_nettype none
// ============================================================================
// Module      : vec_accum
// Description : Element-wise saturating accumulator over valid/ready/last
//               framed packets; emits one widened result vector per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_accum #(
    parameter int INPUT_BW    = 8,
    parameter int OUTPUT_BW   = 16,
    parameter int VECTOR_SIZE = 13
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [VECTOR_SIZE*INPUT_BW-1:0]  data_i,
    input  logic                             valid_i,
    input  logic                             last_i,
    output logic                             ready_o,
    output logic [VECTOR_SIZE*OUTPUT_BW-1:0] data_o,
    output logic                             valid_o,
    output logic                             overflow_o,
    output logic [15:0]                      beats_o,
    input  logic                             ready_i
);

    localparam logic [0:0] c_st_accum  = 1'b0;
    localparam logic [0:0] c_st_output = 1'b1;

    localparam logic signed [OUTPUT_BW-1:0] c_sat_max = {1'b0, {(OUTPUT_BW-1){1'b1}}};
    localparam logic signed [OUTPUT_BW-1:0] c_sat_min = {1'b1, {(OUTPUT_BW-1){1'b0}}};

    logic [0:0]                       r_state;
    logic                             r_live;
    logic                             r_first;
    logic                             r_valid;
    logic                             r_ovf;
    logic [15:0]                      r_beats;
    logic [VECTOR_SIZE*OUTPUT_BW-1:0] r_acc;

    logic [VECTOR_SIZE*OUTPUT_BW-1:0] w_next;
    logic [VECTOR_SIZE-1:0]           w_sat;
    logic                             w_accept;
    logic [15:0]                      w_beats_next;

    // r_live holds ready low for the cycle right after reset
    assign ready_o  = r_live & (r_state == c_st_accum);
    assign w_accept = valid_i & ready_o;

    generate
        for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_lane
            logic signed [INPUT_BW-1:0]  w_in;
            logic signed [OUTPUT_BW-1:0] w_base;
            logic signed [OUTPUT_BW:0]   w_sum;

            assign w_in   = data_i[k*INPUT_BW +: INPUT_BW];
            assign w_base = r_first ? '0 : r_acc[k*OUTPUT_BW +: OUTPUT_BW];
            // One guard bit is enough: a mismatch between the top two bits means overflow
            assign w_sum  = (OUTPUT_BW+1)'(w_base) + (OUTPUT_BW+1)'(w_in);
            assign w_sat[k] = w_sum[OUTPUT_BW] ^ w_sum[OUTPUT_BW-1];
            assign w_next[k*OUTPUT_BW +: OUTPUT_BW] =
                !w_sat[k]        ? w_sum[OUTPUT_BW-1:0] :
                w_sum[OUTPUT_BW] ? c_sat_min : c_sat_max;
        end
    endgenerate

    assign w_beats_next = r_first              ? 16'd1 :
                          (r_beats == 16'hFFFF) ? 16'hFFFF : r_beats + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_accum;
            r_live  <= 1'b0;
            r_first <= 1'b1;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_beats <= 16'd0;
            r_acc   <= '0;
        end else begin
            r_live <= 1'b1;
            if (r_state == c_st_accum) begin
                if (w_accept) begin
                    r_acc   <= w_next;
                    r_ovf   <= (r_first ? 1'b0 : r_ovf) | (|w_sat);
                    r_beats <= w_beats_next;
                    r_first <= 1'b0;
                    if (last_i) begin
                        r_state <= c_st_output;
                        r_valid <= 1'b1;
                    end
                end
            end else begin
                if (ready_i) begin
                    r_state <= c_st_accum;
                    r_valid <= 1'b0;
                    r_first <= 1'b1;
                end
            end
        end
    end

    assign data_o     = r_acc;
    assign valid_o    = r_valid;
    assign overflow_o = r_ovf;
    assign beats_o    = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_vec_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_accum
// Description : Self-checking bench for vec_accum: directed table, corner
//               sequences and random packets against a saturating model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_accum;

    localparam int VS = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic [VS*8-1:0]  data_in;
    logic          valid_in, last_in, ready_out, valid_out, ovf_out, ready_dn;
    logic [VS*16-1:0] data_out;
    logic [15:0]   beats_out;

    logic [VS*8-1:0]  d8_in;
    logic          d8_valid, d8_last, d8_ready, d8_vout, d8_ovf;
    logic [VS*8-1:0]  d8_out;
    logic [15:0]   d8_beats;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vec_accum dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_in), .valid_i(valid_in),
        .last_i(last_in), .ready_o(ready_out), .data_o(data_out),
        .valid_o(valid_out), .overflow_o(ovf_out), .beats_o(beats_out),
        .ready_i(ready_dn)
    );

    vec_accum #(.INPUT_BW(8), .OUTPUT_BW(8), .VECTOR_SIZE(VS)) dut8 (
        .clk_i(clk), .rst_i(rst), .data_i(d8_in), .valid_i(d8_valid),
        .last_i(d8_last), .ready_o(d8_ready), .data_o(d8_out),
        .valid_o(d8_vout), .overflow_o(d8_ovf), .beats_o(d8_beats),
        .ready_i(1'b1)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VS*8-1:0] all8(input int v);
        logic [VS*8-1:0] r;
        for (int k = 0; k < VS; k++) r[k*8 +: 8] = v[7:0];
        return r;
    endfunction

    function automatic logic [VS*16-1:0] all16(input int v);
        logic [VS*16-1:0] r;
        for (int k = 0; k < VS; k++) r[k*16 +: 16] = v[15:0];
        return r;
    endfunction

    task automatic send_beat(input logic [VS*8-1:0] d, input logic l);
        int cnt = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        while (!ready_out && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready_out) check("ready_timeout", 256'(ready_out), 256'(1));
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [VS*16-1:0] exp_d,
                                 input int exp_beats, input logic exp_ovf);
        int cnt = 0;
        while (!valid_out && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_valid"}, 256'(valid_out), 256'(1));
        check({name, "_data"},  256'(data_out),  256'(exp_d));
        check({name, "_beats"}, 256'(beats_out), 256'(exp_beats[15:0]));
        check({name, "_ovf"},   256'(ovf_out),   256'(exp_ovf));
    endtask

    typedef struct {
        int   n;
        int   v0, v1, v2;
        int   exp_lane;
        int   exp_beats;
        logic exp_ovf;
    } vec_t;

    vec_t tbl[4];

    int   m_acc[VS];
    logic m_ovf;

    initial begin
        logic [VS*8-1:0]  din;
        logic [VS*16-1:0] held, expv;

        tbl[0] = '{3,    1,   2,   3,    6, 3, 1'b0};
        tbl[1] = '{1, -128,   0,   0, -128, 1, 1'b0};
        tbl[2] = '{2,  127, 127,   0,  254, 2, 1'b0};
        tbl[3] = '{3,   -1,  -1,  -1,   -3, 3, 1'b0};

        rst = 1'b1; valid_in = 0; last_in = 0; data_in = '0; ready_dn = 1'b1;
        d8_valid = 0; d8_last = 0; d8_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 256'(ready_out), 256'(0));
        check("rst_valid", 256'(valid_out), 256'(0));
        check("rst_data",  256'(data_out),  256'(0));
        check("rst_beats", 256'(beats_out), 256'(0));
        check("rst_ovf",   256'(ovf_out),   256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 256'(ready_out), 256'(1));

        // 8-bit output instance: saturation, then flag and accumulator cleared
        check("d8_ready", 256'(d8_ready), 256'(1));
        d8_valid = 1; d8_in = all8(100); d8_last = 0;
        @(negedge clk);
        d8_last = 1;
        @(negedge clk);
        d8_valid = 0; d8_last = 0;
        check("d8_sat_valid", 256'(d8_vout), 256'(1));
        check("d8_sat_data",  256'(d8_out),  256'(all8(127)));
        check("d8_sat_ovf",   256'(d8_ovf),  256'(1));
        check("d8_sat_beats", 256'(d8_beats), 256'(2));
        @(negedge clk);
        check("d8_ready2", 256'(d8_ready), 256'(1));
        d8_valid = 1; d8_in = all8(-1); d8_last = 1;
        @(negedge clk);
        d8_valid = 0; d8_last = 0;
        check("d8_neg_data",  256'(d8_out),  256'(all8(-1)));
        check("d8_neg_ovf",   256'(d8_ovf),  256'(0));
        check("d8_neg_beats", 256'(d8_beats), 256'(1));

        // Table-driven packets, every lane equal
        for (int i = 0; i < 4; i++) begin
            int vals[3];
            vals = '{tbl[i].v0, tbl[i].v1, tbl[i].v2};
            for (int b = 0; b < tbl[i].n; b++) send_beat(all8(vals[b]), b == tbl[i].n - 1);
            expect_result($sformatf("tbl%0d", i), all16(tbl[i].exp_lane), tbl[i].exp_beats, tbl[i].exp_ovf);
            @(negedge clk);
            check($sformatf("tbl%0d_one_cycle", i), 256'(valid_out), 256'(0));
        end

        // Single beat, lane k = k-6
        for (int k = 0; k < VS; k++) begin
            int s = k - 6;
            din[k*8 +: 8] = s[7:0];
            expv[k*16 +: 16] = s[15:0];
        end
        send_beat(din, 1'b1);
        expect_result("signed_lanes", expv, 1, 1'b0);
        @(negedge clk);

        // Long packet saturating both directions at 16 bits
        for (int k = 0; k < VS; k++) begin
            din[k*8 +: 8]    = (k % 2 == 0) ? 8'sd127 : -8'sd128;
            expv[k*16 +: 16] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
        end
        for (int b = 0; b < 300; b++) send_beat(din, b == 299);
        expect_result("sat16", expv, 300, 1'b1);
        @(negedge clk);

        // Backpressure with a new beat waiting upstream
        ready_dn = 1'b0;
        send_beat(all8(4), 1'b1);
        expect_result("bp_first", all16(4), 1, 1'b0);
        held = data_out;
        valid_in = 1; data_in = all8(9); last_in = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_ready%0d", c), 256'(ready_out), 256'(0));
            check($sformatf("bp_hold%0d", c), 256'(data_out), 256'(held));
        end
        ready_dn = 1'b1;
        @(negedge clk);
        check("bp_released", 256'(valid_out), 256'(0));
        @(negedge clk);
        valid_in = 0; last_in = 0;
        expect_result("bp_second", all16(9), 1, 1'b0);
        @(negedge clk);

        // Reset mid-packet
        send_beat(all8(5), 1'b0);
        send_beat(all8(5), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 256'(ready_out), 256'(0));
        check("midrst_data",  256'(data_out),  256'(0));
        send_beat(all8(2), 1'b1);
        expect_result("midrst", all16(2), 1, 1'b0);
        @(negedge clk);

        // Random packets against a plain-arithmetic saturating model
        ready_dn = 1'b0;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 20);
            m_ovf = 1'b0;
            for (int k = 0; k < VS; k++) m_acc[k] = 0;
            for (int b = 0; b < len; b++) begin
                for (int k = 0; k < VS; k++) begin
                    int s = int'($urandom_range(0, 255));
                    if (s > 127) s -= 256;
                    din[k*8 +: 8] = s[7:0];
                    m_acc[k] += s;
                    if (m_acc[k] > 32767)  begin m_acc[k] = 32767;  m_ovf = 1'b1; end
                    if (m_acc[k] < -32768) begin m_acc[k] = -32768; m_ovf = 1'b1; end
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(din, b == len - 1);
            end
            for (int k = 0; k < VS; k++) expv[k*16 +: 16] = m_acc[k][15:0];
            expect_result($sformatf("rnd%0d", p), expv, len, m_ovf);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check($sformatf("rnd%0d_hold", p), 256'(data_out), 256'(expv));
            end
            ready_dn = 1'b1;
            @(negedge clk);
            ready_dn = 1'b0;
            check($sformatf("rnd%0d_done", p), 256'(valid_out), 256'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
